// File: rtl/mult_stat_pkg.sv
// Shared types for the approximate-multiplier error statistics block.
// FSM states, width helpers and inter-stage pipeline bundles.
package mult_stat_pkg;

  localparam int ED_W   = 16;
  localparam int DIFF_W = 17;

  typedef enum logic [1:0] {
    IDLE,
    ACCUM,
    DRAIN,
    REPORT
  } state_t;

  typedef struct packed {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] r;
  } s1_t;

  typedef struct packed {
    logic [DIFF_W-1:0] diff;
    logic [ED_W-1:0]   ed;
    logic              neq;
  } s2_t;

endpackage

// File: rtl/mult_err_calc.sv
// Exact product and signed/absolute error of one sample.
// Purely combinational; registered by the parent.
module mult_err_calc
  import mult_stat_pkg::*;
(
  input  logic [7:0]  a,
  input  logic [7:0]  b,
  input  logic [15:0] r,
  output s2_t         res
);

  logic [15:0]       p;
  logic [DIFF_W-1:0] diff;

  assign p    = 16'(a) * 16'(b);
  assign diff = {1'b0, r} - {1'b0, p};

  // |diff| never exceeds 65535, so the magnitude fits ED_W
  assign res.diff = diff;
  assign res.ed   = diff[DIFF_W-1] ? ED_W'(-diff)
                                   : diff[ED_W-1:0];
  assign res.neq  = |diff;

endmodule

// File: rtl/mult_err_stat_8x8.sv
// Windowed error statistics for an 8x8 approximate multiplier.
// Three-stage sample pipeline feeding accumulators, one record per window.
module mult_err_stat_8x8
  import mult_stat_pkg::*;
#(
  parameter int WIN_LOG2 = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [7:0]            A,
  input  logic [7:0]            B,
  input  logic [15:0]           R,
  output logic                  res_valid,
  input  logic                  res_ready,
  output logic [16+WIN_LOG2-1:0] ed_sum,
  output logic [15:0]           ed_max,
  output logic [WIN_LOG2:0]     err_cnt,
  output logic [18+WIN_LOG2-1:0] bias_sum,
  output logic                  busy
);

  localparam int SUM_W  = ED_W + WIN_LOG2;
  localparam int BIAS_W = DIFF_W + WIN_LOG2 + 1;

  state_t state_q, state_d;

  logic [WIN_LOG2-1:0] cnt_q;
  logic                v1_q, v2_q;
  s1_t                 s1_q;
  s2_t                 s2_q, s2_d;

  logic [SUM_W-1:0]    acc_sum_q;
  logic [ED_W-1:0]     acc_max_q;
  logic [WIN_LOG2:0]   acc_cnt_q;
  logic [BIAS_W-1:0]   acc_bias_q;

  logic accept, last, go, publish;

  assign in_ready  = (state_q == ACCUM);
  assign res_valid = (state_q == REPORT);
  assign busy      = (state_q != IDLE);
  assign accept    = in_valid & in_ready;
  assign last      = &cnt_q;
  assign go        = (state_q == IDLE) & start;
  assign publish   = (state_q == DRAIN) &
                     (state_d == REPORT);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = ACCUM;
      ACCUM:   if (accept && last) state_d = DRAIN;
      DRAIN:   if (!v1_q && !v2_q) state_d = REPORT;
      REPORT:  if (res_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  mult_err_calc u_calc (
    .a   (s1_q.a),
    .b   (s1_q.b),
    .r   (s1_q.r),
    .res (s2_d)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
      v1_q  <= 1'b0;
      v2_q  <= 1'b0;
      s1_q  <= '0;
      s2_q  <= '0;
    end else begin
      if (go)          cnt_q <= '0;
      else if (accept) cnt_q <= cnt_q + 1'b1;
      v1_q <= accept;
      v2_q <= v1_q;
      if (accept) s1_q <= '{a: A, b: B, r: R};
      if (v1_q)   s2_q <= s2_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n || go) begin
      acc_sum_q  <= '0;
      acc_max_q  <= '0;
      acc_cnt_q  <= '0;
      acc_bias_q <= '0;
    end else if (v2_q) begin
      acc_sum_q  <= acc_sum_q +
                    {{WIN_LOG2{1'b0}}, s2_q.ed};
      acc_cnt_q  <= acc_cnt_q +
                    {{WIN_LOG2{1'b0}}, s2_q.neq};
      acc_bias_q <= acc_bias_q +
        {{(WIN_LOG2+1){s2_q.diff[DIFF_W-1]}}, s2_q.diff};
      if (s2_q.ed > acc_max_q) acc_max_q <= s2_q.ed;
    end
  end

  // Snapshot so the record stays put outside REPORT
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ed_sum   <= '0;
      ed_max   <= '0;
      err_cnt  <= '0;
      bias_sum <= '0;
    end else if (publish) begin
      ed_sum   <= acc_sum_q;
      ed_max   <= acc_max_q;
      err_cnt  <= acc_cnt_q;
      bias_sum <= acc_bias_q;
    end
  end

endmodule

// File: tb/tb_mult_err_stat_8x8.sv
// Scoreboard bench: 16-sample windows on a small instance
// and one full 65536-sample window on a wide instance.
module tb_mult_err_stat_8x8;

  typedef struct {
    longint ed_sum;
    longint ed_max;
    longint err_cnt;
    longint bias_sum;
  } rec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, in_valid, res_ready;
  logic [7:0]  a, b;
  logic [15:0] r;
  logic        in_ready4, res_valid4, busy4;
  logic [19:0] ed_sum4;
  logic [15:0] ed_max4;
  logic [4:0]  err_cnt4;
  logic [21:0] bias_sum4;

  logic        start16, in_valid16, res_ready16;
  logic [7:0]  a16, b16;
  logic [15:0] r16;
  logic        in_ready16, res_valid16, busy16;
  logic [31:0] ed_sum16;
  logic [15:0] ed_max16;
  logic [16:0] err_cnt16;
  logic [33:0] bias_sum16;

  int checks = 0;
  int fails  = 0;
  rec_t exp_q[$];

  mult_err_stat_8x8 #(.WIN_LOG2(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start),
    .in_valid(in_valid), .in_ready(in_ready4),
    .A(a), .B(b), .R(r),
    .res_valid(res_valid4), .res_ready(res_ready),
    .ed_sum(ed_sum4), .ed_max(ed_max4),
    .err_cnt(err_cnt4), .bias_sum(bias_sum4),
    .busy(busy4)
  );

  mult_err_stat_8x8 #(.WIN_LOG2(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start16),
    .in_valid(in_valid16), .in_ready(in_ready16),
    .A(a16), .B(b16), .R(r16),
    .res_valid(res_valid16), .res_ready(res_ready16),
    .ed_sum(ed_sum16), .ed_max(ed_max16),
    .err_cnt(err_cnt16), .bias_sum(bias_sum16),
    .busy(busy16)
  );

  task automatic chk(input string n, input longint act,
                     input longint req);
    checks++;
    if (act != req) begin
      fails++;
      $display("FAIL %s actual=%0d required=%0d",
               n, act, req);
    end
  endtask

  task automatic fail(input string n);
    checks++;
    fails++;
    $display("FAIL %s actual=timeout required=event", n);
  endtask

  function automatic rec_t model(input int sa[$],
                                 input int sb[$],
                                 input int sr[$]);
    rec_t e;
    longint d, ed;
    e = '{0, 0, 0, 0};
    foreach (sa[i]) begin
      d  = longint'(sr[i]) - longint'(sa[i] * sb[i]);
      ed = (d < 0) ? -d : d;
      e.ed_sum   += ed;
      e.bias_sum += d;
      if (ed > e.ed_max) e.ed_max = ed;
      if (d != 0) e.err_cnt++;
    end
    return e;
  endfunction

  always @(negedge clk) begin : mon
    rec_t e;
    #1;
    if (rst_n && res_valid4) begin
      if (exp_q.size() == 0) begin
        fail("unexpected_record");
      end else begin
        e = exp_q[0];
        chk("ed_sum", longint'(ed_sum4), e.ed_sum);
        chk("ed_max", longint'(ed_max4), e.ed_max);
        chk("err_cnt", longint'(err_cnt4), e.err_cnt);
        chk("bias_sum", longint'($signed(bias_sum4)),
            e.bias_sum);
        if (res_ready) void'(exp_q.pop_front());
      end
    end
  end

  // mode 0 exact, 1 = +1 error, 2 = worst first sample
  task automatic run_window(input int mode, input bit rnd,
                            input int hold, input bit poke);
    int n, k, lat;
    int sa[$], sb[$], sr[$];
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    k = 0;
    while (n < 16 && k < 400) begin
      in_valid = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      a = 8'($urandom);
      b = 8'($urandom);
      r = 16'(int'(a) * int'(b) + (mode == 1 ? 1 : 0));
      if (mode == 2 && n == 0) begin
        a = 8'hff; b = 8'hff; r = 16'h0;
      end
      start = poke && (n == 5);
      if (in_valid && in_ready4) begin
        sa.push_back(int'(a));
        sb.push_back(int'(b));
        sr.push_back(int'(r));
        n++;
      end
      k++;
      @(negedge clk);
    end
    start = 1'b0;
    if (n < 16) fail("window_fill");
    exp_q.push_back(model(sa, sb, sr));
    lat = 0;
    res_ready = (hold == 0);
    while (!res_valid4 && lat < 20) begin
      in_valid = 1'b1;
      a = 8'($urandom);
      r = 16'($urandom);
      chk("in_ready_drop", longint'(in_ready4), 0);
      @(negedge clk);
      lat++;
    end
    in_valid = 1'b0;
    // four clocks counting the accepting edge itself
    chk("report_latency", lat, 3);
    for (int i = 0; i < hold; i++) begin
      start = poke && (i == 3);
      @(negedge clk);
    end
    start = 1'b0;
    res_ready = 1'b1;
    k = 0;
    while (exp_q.size() != 0 && k < 50) begin
      @(negedge clk);
      k++;
    end
    res_ready = 1'b0;
    if (exp_q.size() != 0) begin
      fail("record_handoff");
      exp_q.delete();
    end
    chk("busy_idle", longint'(busy4), 0);
  endtask

  task automatic reset_mid;
    int n, k;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    n = 0;
    k = 0;
    while (n < 7 && k < 100) begin
      in_valid = 1'b1;
      a = 8'($urandom);
      b = 8'($urandom);
      r = 16'($urandom);
      if (in_ready4) n++;
      k++;
      @(negedge clk);
    end
    in_valid = 1'b0;
    rst_n = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    chk("rst_busy", longint'(busy4), 0);
    chk("rst_in_ready", longint'(in_ready4), 0);
    chk("rst_res_valid", longint'(res_valid4), 0);
  endtask

  task automatic full_window;
    int k;
    @(negedge clk); start16 = 1'b1;
    @(negedge clk); start16 = 1'b0;
    in_valid16 = 1'b1;
    k = 0;
    while (!res_valid16 && k < 70000) begin
      @(negedge clk);
      k++;
    end
    in_valid16 = 1'b0;
    if (!res_valid16) begin
      fail("w16_report");
    end else begin
      chk("w16_ed_sum", longint'(ed_sum16),
          longint'(65025) * 65536);
      chk("w16_ed_max", longint'(ed_max16), 65025);
      chk("w16_err_cnt", longint'(err_cnt16), 65536);
      chk("w16_bias_sum", longint'($signed(bias_sum16)),
          -longint'(65025) * 65536);
    end
    res_ready16 = 1'b1;
    @(negedge clk);
    res_ready16 = 1'b0;
    chk("w16_release", longint'(res_valid16), 0);
  endtask

  initial begin
    rst_n = 1'b0;
    start = 1'b0;
    in_valid = 1'b0;
    res_ready = 1'b0;
    a = '0; b = '0; r = '0;
    start16 = 1'b0;
    in_valid16 = 1'b0;
    res_ready16 = 1'b0;
    a16 = 8'hff; b16 = 8'hff; r16 = 16'h0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", longint'(in_ready4), 0);
    chk("rst_res_valid", longint'(res_valid4), 0);
    chk("rst_ed_sum", longint'(ed_sum4), 0);
    chk("rst_ed_max", longint'(ed_max4), 0);
    chk("rst_err_cnt", longint'(err_cnt4), 0);
    chk("rst_bias_sum", longint'(bias_sum4), 0);
    chk("rst_busy", longint'(busy4), 0);
    chk("rst_busy16", longint'(busy16), 0);
    chk("rst_in_ready16", longint'(in_ready16), 0);
    rst_n = 1'b1;
    run_window(0, 1'b0, 0, 1'b0);
    run_window(1, 1'b0, 0, 1'b0);
    run_window(2, 1'b0, 0, 1'b0);
    run_window(1, 1'b1, 10, 1'b1);
    run_window(0, 1'b1, 10, 1'b1);
    reset_mid();
    run_window(0, 1'b0, 0, 1'b0);
    run_window(2, 1'b1, 3, 1'b0);
    full_window();
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, fails);
    $finish;
  end

endmodule
